// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Shares one external combinational ALU between two requesters.
//               Round-robin grant, registered operand bus, registered result
//               capture, one-cycle done pulse and a saturating op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [N-1:0]     a0,
  input  logic [N-1:0]     b0,
  input  logic [2:0]       sel0,
  input  logic             ctrl0,
  input  logic             req1,
  input  logic [N-1:0]     a1,
  input  logic [N-1:0]     b1,
  input  logic [2:0]       sel1,
  input  logic             ctrl1,
  output logic             done0,
  output logic             done1,
  output logic [N-1:0]     y_out,
  output logic             cout_out,
  output logic             gnt,
  output logic             busy,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_control,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_cout,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_grant_vld;
  logic             w_grant_idx;

  logic             r_last;
  logic             r_gnt;
  logic [N-1:0]     r_alu_a;
  logic [N-1:0]     r_alu_b;
  logic [2:0]       r_alu_sel;
  logic             r_alu_ctrl;
  logic [N-1:0]     r_y;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_idx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant_vld = 1'b1;
          // On contention the requester that did not win last time goes first.
          w_grant_idx = (req0 && req1) ? ~r_last : req1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch at grant, result capture and bookkeeping at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_alu_ctrl <= 1'b0;
      r_y        <= '0;
      r_cout     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_grant_vld) begin
        r_gnt      <= w_grant_idx;
        r_alu_a    <= w_grant_idx ? a1    : a0;
        r_alu_b    <= w_grant_idx ? b1    : b0;
        r_alu_sel  <= w_grant_idx ? sel1  : sel0;
        r_alu_ctrl <= w_grant_idx ? ctrl1 : ctrl0;
      end
      if (r_state == S_EXEC) begin
        r_y    <= alu_y;
        r_cout <= alu_cout;
        r_last <= r_gnt;
        if (r_cnt != c_CNT_MAX) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  // Done is decoded from the RESP state so it can only reach the granted side.
  assign done0       = (r_state == S_RESP) && !r_gnt;
  assign done1       = (r_state == S_RESP) &&  r_gnt;
  assign busy        = (r_state == S_EXEC) || (r_state == S_RESP);
  assign gnt         = r_gnt;
  assign y_out       = r_y;
  assign cout_out    = r_cout;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign alu_control = r_alu_ctrl;
  assign op_count    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Self-checking bench for alu_rr_arbiter with an adder ALU stub.
//               A cycle-count model predicts every output each cycle; directed
//               literal checks pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

  localparam int N     = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [N-1:0]     a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]       sel0 = '0, sel1 = '0;
  logic             ctrl0 = 1'b0, ctrl1 = 1'b0;
  logic             done0, done1, cout_out, gnt, busy, alu_control, alu_cout;
  logic [N-1:0]     y_out, alu_a, alu_b, alu_y;
  logic [2:0]       alu_sel;
  logic [CNT_W-1:0] op_count;

  int n_vec  = 0;
  int n_miss = 0;

  alu_rr_arbiter #(.N(N), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0), .ctrl0(ctrl0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1), .ctrl1(ctrl1),
    .done0(done0), .done1(done1), .y_out(y_out), .cout_out(cout_out),
    .gnt(gnt), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_control(alu_control),
    .alu_y(alu_y), .alu_cout(alu_cout), .op_count(op_count)
  );

  // ALU stub: plain adder with carry out.
  assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An op granted at edge number g shows busy after edges g and g+1, done and
  // the new result after edge g+1, and the arbiter can grant again at g+3.
  int           cyc     = 0;
  int           m_start = -10;
  bit           m_who   = 1'b0;
  bit           m_last  = 1'b1;
  logic [N:0]   m_sum   = '0;
  logic [N-1:0] e_y = '0, e_a = '0, e_b = '0;
  logic [2:0]   e_sel = '0;
  logic         e_cout = 1'b0, e_ctrl = 1'b0, e_gnt = 1'b0;
  int           e_cnt = 0;

  // Model update on every clock edge, cleared by the reset like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start = cyc - 10;
      m_last  = 1'b1;
      e_y = '0; e_cout = 1'b0; e_cnt = 0; e_gnt = 1'b0;
      e_a = '0; e_b = '0; e_sel = '0; e_ctrl = 1'b0;
    end else begin
      cyc++;
      if (cyc == m_start + 1) begin
        {e_cout, e_y} = m_sum;
        if (e_cnt < CMAX) e_cnt++;
        m_last = m_who;
      end
      if (cyc >= m_start + 3 && (req0 || req1)) begin
        m_who   = (req0 && req1) ? !m_last : req1;
        m_start = cyc;
        e_gnt   = m_who;
        e_a     = m_who ? a1 : a0;
        e_b     = m_who ? b1 : b0;
        e_sel   = m_who ? sel1 : sel0;
        e_ctrl  = m_who ? ctrl1 : ctrl0;
        m_sum   = {1'b0, e_a} + {1'b0, e_b};
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("done0",    32'(done0),    32'((cyc == m_start + 1) && !m_who));
    chk("done1",    32'(done1),    32'((cyc == m_start + 1) &&  m_who));
    chk("busy",     32'(busy),     32'((cyc >= m_start) && (cyc < m_start + 2)));
    chk("gnt",      32'(gnt),      32'(e_gnt));
    chk("y_out",    32'(y_out),    32'(e_y));
    chk("cout_out", 32'(cout_out), 32'(e_cout));
    chk("alu_a",    32'(alu_a),    32'(e_a));
    chk("alu_b",    32'(alu_b),    32'(e_b));
    chk("alu_sel",  32'(alu_sel),  32'(e_sel));
    chk("alu_ctrl", 32'(alu_control), 32'(e_ctrl));
    chk("op_count", 32'(op_count), 32'(e_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input bit who);
    bit seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (who ? done1 : done0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    bit order [4];
    int got;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_y",   32'(y_out),    32'h0);
    chk("rst_cnt", 32'(op_count), 32'h0);
    chk("rst_busy",32'(busy),     32'h0);
    #2 rst_n = 1'b1;

    // Single request: 0F + 01.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h0F; b0 = 8'h01; sel0 = 3'd5; ctrl0 = 1'b1;
    @(negedge clk);
    chk("t1_alu_a", 32'(alu_a), 32'h0F);
    chk("t1_sel",   32'(alu_sel), 32'd5);
    chk("t1_busy",  32'(busy),  32'h1);
    @(negedge clk);
    chk("t1_done0", 32'(done0), 32'h1);
    chk("t1_y",     32'(y_out), 32'h10);
    chk("t1_cout",  32'(cout_out), 32'h0);
    chk("t1_cnt",   32'(op_count), 32'h1);
    chk("t1_gnt",   32'(gnt), 32'h0);
    req0 = 1'b0;
    @(negedge clk);

    // Contention right after reset: expected service order 0,1,0,1.
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (done0 || done1) begin
        order[got] = done1;
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    chk("rr_y", 32'(y_out), 32'h04);
    @(negedge clk);

    // Carry and hold: FF + 02 on requester 1.
    req1 = 1'b1; a1 = 8'hFF; b1 = 8'h02; sel1 = 3'd2; ctrl1 = 1'b0;
    wait_done(1'b1);
    chk("cy_y",    32'(y_out), 32'h01);
    chk("cy_cout", 32'(cout_out), 32'h1);
    chk("cy_gnt",  32'(gnt), 32'h1);
    req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_y", 32'(y_out), 32'h01);
    end

    // Operand change after grant is ignored.
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h03;
    @(negedge clk);
    a0 = 8'h50;
    wait_done(1'b0);
    chk("late_y", 32'(y_out), 32'h08);
    req0 = 1'b0;
    @(negedge clk);

    // Reset during EXEC: no done pulse, everything cleared.
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_done", 32'({done1, done0}), 32'h0);
      chk("ab_y",    32'(y_out), 32'h0);
      chk("ab_a",    32'(alu_a), 32'h0);
      chk("ab_cnt",  32'(op_count), 32'h0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h21; b0 = 8'h22;
    wait_done(1'b0);
    chk("ab_y2",   32'(y_out), 32'h43);
    chk("ab_cnt2", 32'(op_count), 32'h1);
    req0 = 1'b0;
    @(negedge clk);

    // Counter saturation at 3 over five more operations.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        req0 = 1'b1; a0 = 8'(i); b0 = 8'h10;
        wait_done(1'b0);
        req0 = 1'b0;
      end else begin
        req1 = 1'b1; a1 = 8'(i); b1 = 8'h20;
        wait_done(1'b1);
        req1 = 1'b0;
      end
      @(negedge clk);
    end
    chk("sat_cnt", 32'(op_count), 32'd3);
    chk("sat_y",   32'(y_out), 32'h14);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
